// File: rtl/accum_pkg.sv
// Shared defaults, lane/row types and the input sign-extension helper for the accumulator bank.
package accum_pkg;

   localparam int ACC_NUM_COLS = 4;
   localparam int ACC_IN_W     = 16;
   localparam int ACC_W        = 32;
   localparam int ACC_DEPTH    = 8;

   typedef logic signed [ACC_W-1:0]       acc_lane_t;
   typedef acc_lane_t [ACC_NUM_COLS-1:0]  acc_row_t;

   function automatic acc_lane_t sext_in(input logic signed [ACC_IN_W-1:0] x);
      return acc_lane_t'(x);
   endfunction

endpackage

// File: rtl/accumulator_bank_lane.sv
// Combinational per-lane overwrite/accumulate. ACCUM_SATURATE_EN selects clamping on
// accumulate overflow; otherwise the sum wraps and clamp_o stays 0.
module accumulator_lane #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 32
) (
   input  logic                    accumulate_i,
   input  logic signed [ACC_W-1:0] old_i,
   input  logic signed [IN_W-1:0]  in_i,
   output logic signed [ACC_W-1:0] result_o,
   output logic                    clamp_o
);

   logic signed [ACC_W-1:0] ext;
   assign ext = ACC_W'(in_i);

`ifdef ACCUM_SATURATE_EN
   // One guard bit: overflow shows up as disagreement between the top two bits.
   logic signed [ACC_W:0] sum;
   assign sum = {old_i[ACC_W-1], old_i} + {ext[ACC_W-1], ext};

   always_comb begin
      result_o = ext;
      clamp_o  = 1'b0;
      if (accumulate_i) begin
         if (sum[ACC_W] != sum[ACC_W-1]) begin
            clamp_o  = 1'b1;
            result_o = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end else begin
            result_o = sum[ACC_W-1:0];
         end
      end
   end
`else
   assign result_o = accumulate_i ? (old_i + ext) : ext;
   assign clamp_o  = 1'b0;
`endif

endmodule

// File: rtl/accumulator_bank.sv
// Double-buffered NUM_COLS x DEPTH accumulator store with write-bypass echo and a drain read port.
// Optional lane saturation and sticky ovf_flag under macro ACCUM_SATURATE_EN.
module accumulator_bank #(
   parameter  int NUM_COLS = accum_pkg::ACC_NUM_COLS,
   parameter  int IN_W     = accum_pkg::ACC_IN_W,
   parameter  int ACC_W    = accum_pkg::ACC_W,
   parameter  int DEPTH    = accum_pkg::ACC_DEPTH,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_valid,
   input  logic                      wr_accumulate,
   input  logic [AW-1:0]             wr_addr,
   input  logic [NUM_COLS*IN_W-1:0]  wr_data,
   output logic                      acc_valid,
   output logic [NUM_COLS*ACC_W-1:0] acc_data,
   input  logic                      swap,
   output logic                      active_bank,
   input  logic                      rd_req,
   input  logic [AW-1:0]             rd_addr,
   output logic                      rd_valid,
   output logic [NUM_COLS*ACC_W-1:0] rd_data,
   output logic                      ovf_flag
);
   import accum_pkg::*;

   logic [NUM_COLS*ACC_W-1:0] mem_q [2][DEPTH];
   logic                      active_q;
   logic                      acc_valid_q, rd_valid_q, ovf_q, ovf_d;
   logic [NUM_COLS*ACC_W-1:0] acc_data_q, rd_data_q;
   logic [NUM_COLS*ACC_W-1:0] old_row, row_d;
   logic [NUM_COLS-1:0]       clamp;
   logic                      wr_in_range, rd_in_range, clamp_any;

   // Only meaningful when DEPTH is not a power of two; otherwise constant true.
   assign wr_in_range = {1'b0, wr_addr} < (AW+1)'(DEPTH);
   assign rd_in_range = {1'b0, rd_addr} < (AW+1)'(DEPTH);

   assign old_row = wr_in_range ? mem_q[active_q][wr_addr] : '0;

   for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_lane
      accumulator_lane #(
         .IN_W  (IN_W),
         .ACC_W (ACC_W)
      ) u_lane (
         .accumulate_i (wr_accumulate),
         .old_i        (old_row[gi*ACC_W +: ACC_W]),
         .in_i         (wr_data[gi*IN_W +: IN_W]),
         .result_o     (row_d[gi*ACC_W +: ACC_W]),
         .clamp_o      (clamp[gi])
      );
   end

   assign clamp_any = wr_valid & wr_in_range & (|clamp);

   // A swap edge restarts the sticky flag, keeping only a clamp from that same edge.
   always_comb begin
      ovf_d = ovf_q | clamp_any;
      if (swap) begin
         ovf_d = clamp_any;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < DEPTH; r++) begin
               mem_q[b][r] <= '0;
            end
         end
         active_q    <= 1'b0;
         acc_valid_q <= 1'b0;
         acc_data_q  <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         ovf_q       <= 1'b0;
      end else begin
         if (swap) begin
            active_q <= ~active_q;
         end
         acc_valid_q <= wr_valid;
         if (wr_valid) begin
            acc_data_q <= wr_in_range ? row_d : '0;
            if (wr_in_range) begin
               mem_q[active_q][wr_addr] <= row_d;
            end
         end
         rd_valid_q <= rd_req;
         if (rd_req) begin
            rd_data_q <= rd_in_range ? mem_q[~active_q][rd_addr] : '0;
         end
         ovf_q <= ovf_d;
      end
   end

   assign active_bank = active_q;
   assign acc_valid   = acc_valid_q;
   assign acc_data    = acc_data_q;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign ovf_flag    = ovf_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed self-checking bench for accumulator_bank; a second 32-bit-input instance covers overflow.
module tb_accumulator_bank;

   logic         clk;
   logic         reset;
   logic         wr_valid, wr_accumulate, swap, rd_req;
   logic [2:0]   wr_addr, rd_addr;
   logic [63:0]  wr_data;
   logic         acc_valid, active_bank, rd_valid, ovf_flag;
   logic [127:0] acc_data, rd_data;

   logic         w_wr_valid, w_wr_accumulate, w_swap, w_rd_req;
   logic [2:0]   w_wr_addr, w_rd_addr;
   logic [127:0] w_wr_data;
   logic         w_acc_valid, w_active_bank, w_rd_valid, w_ovf_flag;
   logic [127:0] w_acc_data, w_rd_data;

   int total = 0;
   int bad   = 0;

   accumulator_bank u_dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_accumulate (wr_accumulate),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .acc_valid     (acc_valid),
      .acc_data      (acc_data),
      .swap          (swap),
      .active_bank   (active_bank),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .ovf_flag      (ovf_flag)
   );

   accumulator_bank #(
      .NUM_COLS (4),
      .IN_W     (32),
      .ACC_W    (32),
      .DEPTH    (8)
   ) u_dut_w (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (w_wr_valid),
      .wr_accumulate (w_wr_accumulate),
      .wr_addr       (w_wr_addr),
      .wr_data       (w_wr_data),
      .acc_valid     (w_acc_valid),
      .acc_data      (w_acc_data),
      .swap          (w_swap),
      .active_bank   (w_active_bank),
      .rd_req        (w_rd_req),
      .rd_addr       (w_rd_addr),
      .rd_valid      (w_rd_valid),
      .rd_data       (w_rd_data),
      .ovf_flag      (w_ovf_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] row4(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   function automatic logic [63:0] in4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("[%0t] %s ok (%h)", $time, tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      wr_valid = 0; wr_accumulate = 0; wr_addr = 0; wr_data = '0;
      swap = 0; rd_req = 0; rd_addr = 0;
      w_wr_valid = 0; w_wr_accumulate = 0; w_wr_addr = 0; w_wr_data = '0;
      w_swap = 0; w_rd_req = 0; w_rd_addr = 0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      check_val("rst_acc_valid", 128'(acc_valid), 128'(0));
      check_val("rst_rd_valid", 128'(rd_valid), 128'(0));
      check_val("rst_ovf", 128'(ovf_flag), 128'(0));
      check_val("rst_acc_data", acc_data, '0);
      check_val("rst_rd_data", rd_data, '0);
      check_val("rst_active", 128'(active_bank), 128'(0));
      @(posedge clk);
      #3 reset = 1'b1;
      #1;

      // Overwrite then accumulate row 2
      wr_valid = 1; wr_accumulate = 0; wr_addr = 2; wr_data = in4(5, -3, 0, 7);
      tick();
      check_val("ovw_valid", 128'(acc_valid), 128'(1));
      check_val("ovw_data", acc_data, row4(5, -3, 0, 7));
      wr_accumulate = 1; wr_data = in4(1, 1, -1, -8);
      tick();
      check_val("acc_valid", 128'(acc_valid), 128'(1));
      check_val("acc_data", acc_data, row4(6, -2, -1, -1));
      wr_valid = 0; wr_accumulate = 0;
      tick();
      check_val("idle_valid", 128'(acc_valid), 128'(0));
      check_val("idle_hold", acc_data, row4(6, -2, -1, -1));

      // Sign extension of the most negative input
      wr_valid = 1; wr_addr = 3; wr_data = in4(0, -32768, 0, 0);
      tick();
      check_val("sext_lane1", acc_data, row4(0, 32'hFFFF8000, 0, 0));

      // Fill bank 0, confirm bank 1 untouched, swap and drain
      for (int r = 0; r < 8; r++) begin
         wr_valid = 1; wr_accumulate = 0; wr_addr = 3'(r); wr_data = in4(r * 10, 0, 0, 0);
         tick();
      end
      wr_valid = 0;
      rd_req = 1; rd_addr = 0;
      tick();
      check_val("pre_swap_rd_bank1", rd_data, '0);
      rd_req = 0; swap = 1;
      tick();
      swap = 0;
      check_val("swap_active", 128'(active_bank), 128'(1));
      rd_req = 1;
      for (int r = 0; r < 8; r++) begin
         rd_addr = 3'(r);
         tick();
         check_val($sformatf("drain_row%0d", r), rd_data, row4(r * 10, 0, 0, 0));
      end
      rd_req = 0;
      tick();
      check_val("rd_valid_drop", 128'(rd_valid), 128'(0));

      // Same-edge write, swap and read
      wr_valid = 1; wr_addr = 5; wr_data = in4(111, 0, 0, 0);
      tick();
      wr_valid = 0; swap = 1;
      tick();
      swap = 0;
      check_val("swap_back", 128'(active_bank), 128'(0));
      wr_valid = 1; wr_addr = 4; wr_data = in4(222, 0, 0, 0);
      swap = 1; rd_req = 1; rd_addr = 5;
      tick();
      wr_valid = 0; swap = 0;
      check_val("same_edge_rd", rd_data, row4(111, 0, 0, 0));
      check_val("same_edge_wr", acc_data, row4(222, 0, 0, 0));
      check_val("same_edge_active", 128'(active_bank), 128'(1));
      rd_addr = 4;
      tick();
      check_val("same_edge_landed_b0", rd_data, row4(222, 0, 0, 0));
      rd_addr = 5;
      tick();
      check_val("drain_not_active", rd_data, row4(50, 0, 0, 0));
      rd_req = 0;

      // Overflow on the 32-bit-input instance
      w_wr_valid = 1; w_wr_accumulate = 0; w_wr_addr = 0; w_wr_data = row4(32'h7FFFFFF0, 0, 0, 0);
      tick();
      check_val("ovf_pre", w_acc_data, row4(32'h7FFFFFF0, 0, 0, 0));
      w_wr_accumulate = 1; w_wr_data = row4(32'h20, 0, 0, 0);
      tick();
      w_wr_valid = 0; w_wr_accumulate = 0;
`ifdef ACCUM_SATURATE_EN
      check_val("ovf_result", w_acc_data, row4(32'h7FFFFFFF, 0, 0, 0));
      check_val("ovf_flag_set", 128'(w_ovf_flag), 128'(1));
      tick();
      check_val("ovf_flag_sticky", 128'(w_ovf_flag), 128'(1));
`else
      check_val("ovf_result", w_acc_data, row4(32'h80000010, 0, 0, 0));
      check_val("ovf_flag_set", 128'(w_ovf_flag), 128'(0));
      tick();
      check_val("ovf_flag_sticky", 128'(w_ovf_flag), 128'(0));
`endif
      w_swap = 1;
      tick();
      w_swap = 0;
      check_val("ovf_swap_clear", 128'(w_ovf_flag), 128'(0));

      // Asynchronous reset in the middle of an accumulate/read burst
      wr_valid = 1; wr_accumulate = 1; wr_data = in4(3, 3, 3, 3); rd_req = 1;
      for (int r = 0; r < 2; r++) begin
         wr_addr = 3'(r); rd_addr = 3'(r);
         tick();
      end
      #3 reset = 1'b0;
      #1;
      check_val("arst_acc_valid", 128'(acc_valid), 128'(0));
      check_val("arst_acc_data", acc_data, '0);
      check_val("arst_rd_valid", 128'(rd_valid), 128'(0));
      check_val("arst_rd_data", rd_data, '0);
      check_val("arst_active", 128'(active_bank), 128'(0));
      wr_valid = 0; wr_accumulate = 0; rd_req = 0;
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      rd_req = 1;
      for (int r = 0; r < 8; r++) begin
         rd_addr = 3'(r);
         tick();
         check_val($sformatf("post_rst_b1_row%0d", r), rd_data, '0);
      end
      rd_req = 0; swap = 1;
      tick();
      swap = 0; rd_req = 1;
      for (int r = 0; r < 8; r++) begin
         rd_addr = 3'(r);
         tick();
         check_val($sformatf("post_rst_b0_row%0d", r), rd_data, '0);
      end
      check_val("post_rst_rd_valid", 128'(rd_valid), 128'(1));
      rd_req = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
